ext_irq_requester: RTL and testbench

// - Requester end of the processor's external-interrupt handshake: collects N_SRC peripheral interrupt lines.
// - Latches rising edges as pending, picks the highest-priority source and raises ExtIRQ to the processor.
// - Holds the request until the processor returns ExtlAck, then retires that source.
// - Sits beside the single-cycle core; ExtIRQ and ExtlAck connect straight to the controller's ports of the same name.

---
 rtl/ext_irq_pkg.sv | 8 +
 rtl/ext_irq_requester_if.sv | 22 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/ext_irq_requester.sv | 93 +++++++++
 tb/tb_ext_irq_requester.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_irq_pkg.sv
// Shared types and limits for the external-interrupt requester.
package ext_irq_pkg;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACK} irq_state_t;

  localparam int unsigned MAX_SRC = 16;

endpackage

// File: rtl/ext_irq_requester_if.sv
// Processor-side interrupt handshake: request/id from the requester, acknowledge back.
interface ext_irq_requester_if #(
  parameter int unsigned ID_W = 2
);

  logic            ExtIRQ;
  logic            ExtlAck;
  logic [ID_W-1:0] irq_id;

  modport master (
    output ExtIRQ,
    output irq_id,
    input  ExtlAck
  );

  modport slave (
    input  ExtIRQ,
    input  irq_id,
    output ExtlAck
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Walk downwards so the lowest set bit is the last to overwrite idx.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_irq_requester.sv
// Collects peripheral interrupt edges and drives the processor's ExtIRQ/ExtlAck handshake.
// Optional per-source enable mask when EXT_IRQ_MASK_EN is defined.
module ext_irq_requester
  import ext_irq_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    irq_src,
`ifdef EXT_IRQ_MASK_EN
  input  logic [N_SRC-1:0]    irq_mask,
`endif
  output logic [N_SRC-1:0]    irq_pending,
  ext_irq_requester_if.master irq_bus
);

  irq_state_t       state;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic             win_any;
  logic [ID_W-1:0]  win_idx;

  assign rise = irq_src & ~src_q;

  // Masking only gates eligibility; pending bits are never dropped by it.
  always_comb begin
`ifdef EXT_IRQ_MASK_EN
    eligible = irq_pending & irq_mask;
`else
    eligible = irq_pending;
`endif
  end

  always_comb begin
    clr = '0;
    if (state == IRQ_REQ && irq_bus.ExtlAck) begin
      clr[irq_bus.irq_id] = 1'b1;
    end
  end

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req (eligible),
    .any (win_any),
    .idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IRQ_IDLE;
      src_q          <= '0;
      irq_pending    <= '0;
      irq_bus.ExtIRQ <= 1'b0;
      irq_bus.irq_id <= '0;
    end else begin
      src_q       <= irq_src;
      // A fresh edge in the clearing cycle survives: set wins over clear.
      irq_pending <= (irq_pending & ~clr) | rise;
      unique case (state)
        IRQ_IDLE: begin
          if (win_any) begin
            state          <= IRQ_REQ;
            irq_bus.ExtIRQ <= 1'b1;
            irq_bus.irq_id <= win_idx;
          end
        end
        IRQ_REQ: begin
          // No preemption: the latched id is held until acknowledged.
          if (irq_bus.ExtlAck) begin
            state          <= IRQ_ACK;
            irq_bus.ExtIRQ <= 1'b0;
          end
        end
        IRQ_ACK: begin
          if (!irq_bus.ExtlAck) begin
            state <= IRQ_IDLE;
          end
        end
        default: begin
          state          <= IRQ_IDLE;
          irq_bus.ExtIRQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_requester.sv
// Directed bench for ext_irq_requester with a cycle-level reference model.
// Define EXT_IRQ_MASK_EN to also exercise the mask port.
module tb_ext_irq_requester;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned ID_W  = 2;

  logic             clk;
  logic             reset;
  logic [N_SRC-1:0] src;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic             ack;
  logic             auto_ack;
  logic             check_en;

  int total;
  int bad;

  ext_irq_requester_if #(.ID_W(ID_W)) bus ();

  assign bus.ExtlAck = ack;

  ext_irq_requester #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (src),
`ifdef EXT_IRQ_MASK_EN
    .irq_mask    (mask),
`endif
    .irq_pending (pending),
    .irq_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [ID_W-1:0] lowest(input logic [N_SRC-1:0] v);
    for (int i = 0; i < N_SRC; i++) begin
      if (v[i]) return ID_W'(i);
    end
    return '0;
  endfunction

  // Reference model: pending set, an outstanding request, and a wait-for-ack-release flag.
  logic [N_SRC-1:0] m_prev;
  logic [N_SRC-1:0] m_pend;
  logic             m_req;
  logic [ID_W-1:0]  m_id;
  logic             m_wait;

  always @(posedge clk) begin : model
    logic [N_SRC-1:0] r;
    logic [N_SRC-1:0] c;
    logic [N_SRC-1:0] e;
    if (!reset) begin
      m_prev <= '0;
      m_pend <= '0;
      m_req  <= 1'b0;
      m_id   <= '0;
      m_wait <= 1'b0;
    end else begin
      r = src & ~m_prev;
      c = '0;
      if (m_req && ack) c = 4'b0001 << m_id;
      e = m_pend & mask;
      m_prev <= src;
      m_pend <= (m_pend & ~c) | r;
      if (m_wait) begin
        if (!ack) m_wait <= 1'b0;
      end else if (m_req) begin
        if (ack) begin
          m_req  <= 1'b0;
          m_wait <= 1'b1;
        end
      end else if (e != '0) begin
        m_req <= 1'b1;
        m_id  <= lowest(e);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_ExtIRQ", 32'(bus.ExtIRQ), 32'(m_req));
      if (m_req) check("cyc_irq_id", 32'(bus.irq_id), 32'(m_id));
      check("cyc_pending", 32'(pending), 32'(m_pend));
    end
  end

  // Processor stand-in: acknowledge is ExtIRQ delayed into the next cycle.
  always @(posedge clk) begin
    #1;
    if (auto_ack) ack = bus.ExtIRQ;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    src      = '0;
    mask     = '1;
    ack      = 1'b0;
    auto_ack = 1'b0;
    check_en = 1'b0;
    repeat (2) tick();
    check("rst_ExtIRQ", 32'(bus.ExtIRQ), 32'd0);
    check("rst_irq_id", 32'(bus.irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset    = 1'b1;
    check_en = 1'b1;
    tick();

    // Stray acknowledge while idle.
    ack = 1'b1;
    repeat (2) tick();
    check("idle_ack_ExtIRQ", 32'(bus.ExtIRQ), 32'd0);
    check("idle_ack_pending", 32'(pending), 32'd0);
    ack = 1'b0;
    tick();

    // Single edge on src2 with automatic acknowledge.
    auto_ack = 1'b1;
    src = 4'b0100;
    tick();
    src = 4'b0000;
    check("single_pend", 32'(pending), 32'h4);
    check("single_early", 32'(bus.ExtIRQ), 32'd0);
    tick();
    check("single_ExtIRQ", 32'(bus.ExtIRQ), 32'd1);
    check("single_id", 32'(bus.irq_id), 32'd2);
    tick();
    check("single_drop", 32'(bus.ExtIRQ), 32'd0);
    check("single_clr", 32'(pending), 32'h0);
    repeat (3) tick();

    // Two simultaneous edges: src1 then src3.
    src = 4'b1010;
    tick();
    tick();
    check("simul_first", 32'(bus.irq_id), 32'd1);
    check("simul_first_req", 32'(bus.ExtIRQ), 32'd1);
    repeat (3) tick();
    check("simul_second_req", 32'(bus.ExtIRQ), 32'd1);
    check("simul_second", 32'(bus.irq_id), 32'd3);
    repeat (2) tick();
    check("simul_end_pend", 32'(pending), 32'h0);
    check("simul_end_req", 32'(bus.ExtIRQ), 32'd0);
    src = 4'b0000;
    repeat (3) tick();

    // Request held without acknowledge; higher index arrives meanwhile.
    auto_ack = 1'b0;
    ack = 1'b0;
    src = 4'b0001;
    tick();
    src = 4'b0000;
    tick();
    repeat (3) tick();
    src = 4'b1000;
    tick();
    src = 4'b0000;
    repeat (15) tick();
    check("hold_req", 32'(bus.ExtIRQ), 32'd1);
    check("hold_id", 32'(bus.irq_id), 32'd0);
    check("hold_pend", 32'(pending), 32'h9);
    ack = 1'b1;
    tick();
    check("hold_acked", 32'(bus.ExtIRQ), 32'd0);
    ack = 1'b0;
    repeat (2) tick();
    check("hold_next_req", 32'(bus.ExtIRQ), 32'd1);
    check("hold_next_id", 32'(bus.irq_id), 32'd3);
    ack_pulse();
    check("hold_end_pend", 32'(pending), 32'h0);

    // Re-edge on src1 in the same cycle it is acknowledged.
    src = 4'b0010;
    tick();
    src = 4'b0000;
    tick();
    check("svc_id", 32'(bus.irq_id), 32'd1);
    ack = 1'b1;
    src = 4'b0010;
    tick();
    check("svc_pend", 32'(pending), 32'h2);
    check("svc_drop", 32'(bus.ExtIRQ), 32'd0);
    ack = 1'b0;
    src = 4'b0000;
    repeat (2) tick();
    check("svc_rereq", 32'(bus.ExtIRQ), 32'd1);
    check("svc_reid", 32'(bus.irq_id), 32'd1);
    ack_pulse();

    // Reset in the middle of a request, source held high throughout.
    src = 4'b0100;
    repeat (2) tick();
    check("rreq_req", 32'(bus.ExtIRQ), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rreq_ExtIRQ", 32'(bus.ExtIRQ), 32'd0);
      check("rreq_pend", 32'(pending), 32'h0);
    end
    check("rreq_id", 32'(bus.irq_id), 32'd0);
    src = 4'b0000;
    reset = 1'b1;
    repeat (4) tick();
    check("rreq_quiet", 32'(bus.ExtIRQ), 32'd0);

`ifdef EXT_IRQ_MASK_EN
    // Masked source stays pending until enabled.
    mask = 4'b1110;
    src = 4'b0001;
    tick();
    src = 4'b0000;
    repeat (4) tick();
    check("mask_noreq", 32'(bus.ExtIRQ), 32'd0);
    check("mask_pend", 32'(pending), 32'h1);
    mask = 4'b1111;
    repeat (2) tick();
    check("mask_req", 32'(bus.ExtIRQ), 32'd1);
    check("mask_id", 32'(bus.irq_id), 32'd0);
    ack_pulse();
    check("mask_end_pend", 32'(pending), 32'h0);
`endif

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
